// File: rtl/count_wrap_monitor_if.sv
// Bus between a counter-side agent and the count_wrap_monitor.
// The master drives the observed count and the clear strobe. The slave (the
// monitor) returns the registered status view of the counter.
interface count_wrap_monitor_if #(
    parameter int CNT_W  = 4,
    parameter int WRAP_W = 8
);
    // Observed counter value and synchronous clear.
    logic [CNT_W-1:0]  count;
    logic              clear;

    // Registered monitor status.
    logic              wrap_up;
    logic              wrap_down;
    logic              step_err;
    logic              err_sticky;
    logic              dir;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              stall;
    logic              primed;

    // Agent side: supplies the count, consumes the status.
    modport master (
        output count,
        output clear,
        input  wrap_up,
        input  wrap_down,
        input  step_err,
        input  err_sticky,
        input  dir,
        input  wrap_cnt,
        input  stall,
        input  primed
    );

    // Monitor side: consumes the count, produces the status.
    modport slave (
        input  count,
        input  clear,
        output wrap_up,
        output wrap_down,
        output step_err,
        output err_sticky,
        output dir,
        output wrap_cnt,
        output stall,
        output primed
    );
endinterface

// File: rtl/count_wrap_monitor.sv
// Passive observer for an up/down counter. Every clock it compares the new
// count against the previous sample and classifies the transition as an up
// step, a down step, a hold or an illegal jump. It pulses on wrap-around and
// illegal steps, keeps a saturating wrap tally and a sticky error flag, and
// detects a counter that has stopped moving for STALL_LIM samples.
// All outputs come straight from flops; nothing from count/clear reaches an
// output combinationally.
// STALL_LIM must lie in 1..255 so that it fits the 8-bit stall counter.
module count_wrap_monitor #(
    parameter int CNT_W     = 4,
    parameter int WRAP_W    = 8,
    parameter int STALL_LIM = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    count_wrap_monitor_if.slave  bus
);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [WRAP_W-1:0] WRAP_MAX  = '1;
    localparam logic [7:0]        STALL_MAX = 8'(STALL_LIM);

    // UNPRIMED: no reference sample yet.
    // TRACK:    counter is being followed normally.
    // STALLED:  STALL_LIM consecutive equal samples seen.
    typedef enum logic [1:0] {
        UNPRIMED = 2'd0,
        TRACK    = 2'd1,
        STALLED  = 2'd2
    } state_t;

    state_t            state,        state_d;
    logic [CNT_W-1:0]  prev,         prev_d;
    logic [7:0]        stall_cnt,    stall_cnt_d;
    logic              wrap_up_q,    wrap_up_d;
    logic              wrap_down_q,  wrap_down_d;
    logic              step_err_q,   step_err_d;
    logic              err_sticky_q, err_sticky_d;
    logic              dir_q,        dir_d;
    logic [WRAP_W-1:0] wrap_cnt_q,   wrap_cnt_d;

    // Transition decode shared by the classifier below.
    logic [CNT_W-1:0]  delta;
    logic              is_hold;
    logic              is_up;
    logic              is_down;
    logic              is_wrap_up;
    logic              is_wrap_down;

    // Modular difference between the new sample and the reference, plus the
    // wrap-edge detectors. The wrap detectors look at the absolute values so
    // that a 1-bit counter can report alternating up/down wraps.
    always_comb begin
        delta        = bus.count - prev;
        is_hold      = (delta == CNT_ZERO);
        is_up        = (delta == CNT_ONE);
        is_down      = (delta == CNT_MAX);
        is_wrap_up   = (prev == CNT_MAX)  && (bus.count == CNT_ZERO);
        is_wrap_down = (prev == CNT_ZERO) && (bus.count == CNT_MAX);
    end

    // Next-state and next-output logic for the monitor FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch instead of logic.
        state_d      = state;
        prev_d       = prev;
        stall_cnt_d  = stall_cnt;
        wrap_up_d    = 1'b0;
        wrap_down_d  = 1'b0;
        step_err_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        dir_d        = dir_q;
        wrap_cnt_d   = wrap_cnt_q;

        unique case (state)
            UNPRIMED: begin
                // First sample only establishes the reference; no events.
                prev_d  = bus.count;
                state_d = TRACK;
            end

            TRACK, STALLED: begin
                prev_d = bus.count;

                if (is_hold) begin
                    if (stall_cnt >= STALL_MAX) begin
                        stall_cnt_d = STALL_MAX;
                    end else begin
                        stall_cnt_d = stall_cnt + 8'd1;
                    end
                end else begin
                    stall_cnt_d = 8'd0;
                    wrap_up_d   = is_wrap_up;
                    wrap_down_d = is_wrap_down;
                    if (is_up) begin
                        dir_d = 1'b1;
                    end else if (is_down) begin
                        dir_d = 1'b0;
                    end else begin
                        step_err_d   = 1'b1;
                        err_sticky_d = 1'b1;
                    end
                end

                // Either wrap direction bumps the tally, which never rolls over.
                if ((wrap_up_d || wrap_down_d) && (wrap_cnt_q != WRAP_MAX)) begin
                    wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                end
            end

            default: begin
                // Unreachable encoding: re-prime from scratch.
                state_d = UNPRIMED;
            end
        endcase

        // Clear overrides the accumulated state but leaves this edge's pulses,
        // the reference sample and the direction alone.
        if (bus.clear) begin
            wrap_cnt_d   = '0;
            err_sticky_d = 1'b0;
            stall_cnt_d  = 8'd0;
        end

        // Stall entry uses the post-clear count so a clear on the limiting
        // hold keeps the FSM in TRACK; any movement or a clear leaves STALLED.
        if (state == TRACK && stall_cnt_d == STALL_MAX) begin
            state_d = STALLED;
        end else if (state == STALLED && (!is_hold || bus.clear)) begin
            state_d = TRACK;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= UNPRIMED;
            prev         <= '0;
            stall_cnt    <= 8'd0;
            wrap_up_q    <= 1'b0;
            wrap_down_q  <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            dir_q        <= 1'b0;
            wrap_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // values from before this edge, independent of statement order.
            state        <= state_d;
            prev         <= prev_d;
            stall_cnt    <= stall_cnt_d;
            wrap_up_q    <= wrap_up_d;
            wrap_down_q  <= wrap_down_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
            dir_q        <= dir_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    // stall and primed are decodes of the registered FSM state only.
    assign bus.wrap_up    = wrap_up_q;
    assign bus.wrap_down  = wrap_down_q;
    assign bus.step_err   = step_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.dir        = dir_q;
    assign bus.wrap_cnt   = wrap_cnt_q;
    assign bus.stall      = (state == STALLED);
    assign bus.primed     = (state != UNPRIMED);

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor. dut_a uses the default parameters and
// is checked against a table of hand-computed vectors; dut_b (WRAP_W=2) shares
// the stimulus and is used for wrap-tally saturation. Hand-written sequences
// cover saturation, clear/wrap priority and an asynchronous mid-stream reset.
module tb_count_wrap_monitor;

    typedef struct packed {
        logic       wu;
        logic       wd;
        logic       se;
        logic       es;
        logic       dir;
        logic [7:0] wc;
        logic       stall;
        logic       primed;
    } out_t;

    typedef struct {
        logic [3:0] cnt;
        logic       clr;
        out_t       exp;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [3:0] cnt_in = 4'd0;
    logic       clr_in = 1'b0;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    count_wrap_monitor_if #(.CNT_W(4), .WRAP_W(8)) ifc_a ();
    count_wrap_monitor_if #(.CNT_W(4), .WRAP_W(2)) ifc_b ();

    assign ifc_a.count = cnt_in;
    assign ifc_a.clear = clr_in;
    assign ifc_b.count = cnt_in;
    assign ifc_b.clear = clr_in;

    count_wrap_monitor #(.CNT_W(4), .WRAP_W(8), .STALL_LIM(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc_a.slave)
    );

    count_wrap_monitor #(.CNT_W(4), .WRAP_W(2), .STALL_LIM(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc_b.slave)
    );

    out_t act_a;
    out_t act_b;
    assign act_a = {ifc_a.wrap_up, ifc_a.wrap_down, ifc_a.step_err, ifc_a.err_sticky,
                    ifc_a.dir, ifc_a.wrap_cnt, ifc_a.stall, ifc_a.primed};
    assign act_b = {ifc_b.wrap_up, ifc_b.wrap_down, ifc_b.step_err, ifc_b.err_sticky,
                    ifc_b.dir, 6'd0, ifc_b.wrap_cnt, ifc_b.stall, ifc_b.primed};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "time limit");
    end

    function automatic out_t mk(input logic wu, input logic wd, input logic se,
                                input logic es, input logic dir, input logic [7:0] wc,
                                input logic st);
        out_t o;
        o.wu = wu; o.wd = wd; o.se = se; o.es = es; o.dir = dir;
        o.wc = wc; o.stall = st; o.primed = 1'b1;
        return o;
    endfunction

    task automatic add(input logic [3:0] c, input logic cl, input out_t e);
        vec_t v;
        v.cnt = c;
        v.clr = cl;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Drive one sample between edges, then look 1 ns after the edge.
    task automatic step(input logic [3:0] c, input logic cl);
        cnt_in = c;
        clr_in = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- vector table ----------------
        // Priming sample: no events, primed rises.
        add(4'd0, 1'b0, mk(0, 0, 0, 0, 0, 8'd0, 0));
        // Count up 1..15, then wrap to 0.
        for (int c = 1; c <= 15; c++) add(4'(c), 1'b0, mk(0, 0, 0, 0, 1, 8'd0, 0));
        add(4'd0, 1'b0, mk(1, 0, 0, 0, 1, 8'd1, 0));
        add(4'd1, 1'b0, mk(0, 0, 0, 0, 1, 8'd1, 0));
        add(4'd2, 1'b0, mk(0, 0, 0, 0, 1, 8'd1, 0));
        // Down 2,1,0,15,14 with the wrap at 0->15.
        add(4'd1,  1'b0, mk(0, 0, 0, 0, 0, 8'd1, 0));
        add(4'd0,  1'b0, mk(0, 0, 0, 0, 0, 8'd1, 0));
        add(4'd15, 1'b0, mk(0, 1, 0, 0, 0, 8'd2, 0));
        add(4'd14, 1'b0, mk(0, 0, 0, 0, 0, 8'd2, 0));
        for (int c = 13; c >= 5; c--) add(4'(c), 1'b0, mk(0, 0, 0, 0, 0, 8'd2, 0));
        // Hold at 5: stall rises on the 8th equal sample and stays.
        for (int i = 1; i <= 7; i++) add(4'd5, 1'b0, mk(0, 0, 0, 0, 0, 8'd2, 0));
        add(4'd5, 1'b0, mk(0, 0, 0, 0, 0, 8'd2, 1));
        add(4'd5, 1'b0, mk(0, 0, 0, 0, 0, 8'd2, 1));
        // Move to 6: stall falls, dir up.
        add(4'd6, 1'b0, mk(0, 0, 0, 0, 1, 8'd2, 0));
        // Down to 3, then illegal 3->7: dir stays 0.
        add(4'd5, 1'b0, mk(0, 0, 0, 0, 0, 8'd2, 0));
        add(4'd4, 1'b0, mk(0, 0, 0, 0, 0, 8'd2, 0));
        add(4'd3, 1'b0, mk(0, 0, 0, 0, 0, 8'd2, 0));
        add(4'd7, 1'b0, mk(0, 0, 1, 1, 0, 8'd2, 0));
        add(4'd8, 1'b0, mk(0, 0, 0, 1, 1, 8'd2, 0));
        // Clear on an up step: sticky and tally drop.
        add(4'd9, 1'b1, mk(0, 0, 0, 0, 1, 8'd0, 0));
        for (int c = 10; c <= 15; c++) add(4'(c), 1'b0, mk(0, 0, 0, 0, 1, 8'd0, 0));
        add(4'd0, 1'b0, mk(1, 0, 0, 0, 1, 8'd1, 0));
        for (int c = 1; c <= 15; c++) add(4'(c), 1'b0, mk(0, 0, 0, 0, 1, 8'd1, 0));
        // Clear on the wrap edge: pulse fires, tally 0.
        add(4'd0, 1'b1, mk(1, 0, 0, 0, 1, 8'd0, 0));
        // Clear on an illegal step: pulse fires, sticky stays 0.
        add(4'd5, 1'b1, mk(0, 0, 1, 0, 1, 8'd0, 0));
        // Stall again, clear while stalled, then stall once more.
        for (int i = 1; i <= 7; i++) add(4'd5, 1'b0, mk(0, 0, 0, 0, 1, 8'd0, 0));
        add(4'd5, 1'b0, mk(0, 0, 0, 0, 1, 8'd0, 1));
        add(4'd5, 1'b1, mk(0, 0, 0, 0, 1, 8'd0, 0));
        for (int i = 1; i <= 7; i++) add(4'd5, 1'b0, mk(0, 0, 0, 0, 1, 8'd0, 0));
        add(4'd5, 1'b0, mk(0, 0, 0, 0, 1, 8'd0, 1));

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", 32'(act_a), 32'd0);
        check("reset_b", 32'(act_b), 32'd0);
        #3 reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].cnt, vecs[i].clr);
            check($sformatf("vec%0d_cnt%0d", i, vecs[i].cnt), 32'(act_a), 32'(vecs[i].exp));
        end

        // ---------------- tally saturation (dut_b, WRAP_W=2) ----------------
        for (int c = 4; c >= 0; c--) step(4'(c), 1'b0);
        step(4'd15, 1'b0);
        step(4'd0, 1'b0);
        step(4'd15, 1'b0);
        check("sat_b_third", 32'(ifc_b.wrap_cnt), 32'd3);
        step(4'd0, 1'b0);
        check("sat_b_fourth", 32'(ifc_b.wrap_cnt), 32'd3);
        step(4'd15, 1'b0);
        check("sat_b_fifth", 32'(ifc_b.wrap_cnt), 32'd3);
        check("sat_a_fifth", 32'(ifc_a.wrap_cnt), 32'd5);
        step(4'd0, 1'b1);
        check("clr_wrap_b_cnt", 32'(ifc_b.wrap_cnt), 32'd0);
        check("clr_wrap_b_pulse", 32'(ifc_b.wrap_up), 32'd1);
        check("clr_wrap_a_cnt", 32'(ifc_a.wrap_cnt), 32'd0);
        step(4'd1, 1'b0);
        check("wrap_pulse_width", 32'(ifc_b.wrap_up), 32'd0);

        // ---------------- asynchronous reset mid-stream ----------------
        step(4'd0, 1'b0);
        step(4'd15, 1'b0);
        step(4'd0, 1'b0);
        for (int i = 0; i < 8; i++) step(4'd0, 1'b0);
        check("pre_reset_wc", 32'(ifc_a.wrap_cnt), 32'd2);
        check("pre_reset_stall", 32'(ifc_a.stall), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_a", 32'(act_a), 32'd0);
        check("async_reset_b", 32'(act_b), 32'd0);
        #3 reset = 1'b0;
        step(4'd9, 1'b0);
        check("reprime", 32'(act_a), 32'(mk(0, 0, 0, 0, 0, 8'd0, 0)));
        step(4'd10, 1'b0);
        check("after_reprime", 32'(act_a), 32'(mk(0, 0, 0, 0, 1, 8'd0, 0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_wrap_monitor.md
# count_wrap_monitor

Downstream observer for the 4-bit up/down counter. It samples the counter's `count` output every clock and classifies each transition as an up step, a down step, a hold or an illegal jump. It flags wrap-around events and keeps a saturating wrap tally. It also detects a stalled counter, giving the system a registered health and status view of the counter without touching its datapath.

## Interface
- `CNT_W`, default 4: width of the observed count.
- `WRAP_W`, default 8: width of the wrap tally.
- `STALL_LIM`, default 8: number of consecutive equal samples that declares a stall. Legal range is 1 to 255.

Ports:
- `clk`, input, 1: system clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `count`, input, CNT_W: counter value, synchronous to `clk`.
- `clear`, input, 1: synchronous clear of `wrap_cnt`, `err_sticky` and the stall counter.
- `wrap_up`, output, 1: one-cycle pulse on a max→0 transition.
- `wrap_down`, output, 1: one-cycle pulse on a 0→max transition.
- `step_err`, output, 1: one-cycle pulse on a non-unit, non-zero step.
- `err_sticky`, output, 1: set by `step_err`, held until `clear` or `reset`.
- `dir`, output, 1: direction of the last legal step (1 = up, 0 = down).
- `wrap_cnt`, output, WRAP_W: saturating count of wrap events in either direction.
- `stall`, output, 1: high while the FSM is in STALLED.
- `primed`, output, 1: high once a reference sample has been captured.

## Operation
- Internal state:
  - `prev`, CNT_W bits: last sampled count.
  - `stall_cnt`, 8 bits: saturates at STALL_LIM.
  - FSM: UNPRIMED, TRACK, STALLED.
- On every edge where `primed`=1, compute `delta = count − prev` modulo 2^CNT_W, then set `prev ← count`.
- UNPRIMED is the reset state. On the first edge: capture `prev ← count`, set `primed`=1, go to TRACK. No events are emitted on this edge.
- TRACK and STALLED classify each sample by `delta`:
  - **delta = 1 (up):** `dir` ← 1. If `prev` = 2^CNT_W−1 and `count` = 0: pulse `wrap_up`.
  - **delta = 2^CNT_W−1 (down):** `dir` ← 0. If `prev` = 0 and `count` = 2^CNT_W−1: pulse `wrap_down`.
  - **delta = 0 (hold):** `stall_cnt` ← min(`stall_cnt`+1, STALL_LIM). `dir` is unchanged.
  - **Any other delta:** pulse `step_err`, set `err_sticky`. `dir` is unchanged.
- Any non-zero delta clears `stall_cnt` to 0.
- FSM transitions:
  - TRACK → STALLED on the edge where `stall_cnt` reaches STALL_LIM.
  - STALLED → TRACK on the first non-zero delta, which is classified normally on that same edge.
- Wrap tally: each `wrap_up` or `wrap_down` event increments `wrap_cnt`. It saturates at 2^WRAP_W−1 and never rolls over.
- `clear` behaviour:
  - Zeroes `wrap_cnt`, `err_sticky` and `stall_cnt`, and returns STALLED → TRACK.
  - Does not affect `prev`, `primed` or `dir`.
  - Event pulses on the same edge are still emitted.
- Simultaneous `clear` and an event: `clear` wins for state, so `wrap_cnt`=0 and `err_sticky`=0. The pulse output still fires.
- Mid-operation `reset`: everything returns immediately to its reset values. The block re-primes on the first edge after deassertion.

## Timing
- Reset values, applied asynchronously while `reset`=1: all outputs are 0, `prev`=0, `stall_cnt`=0, FSM in UNPRIMED.
- Every output is registered, with no combinational path from `count` or `clear` to any output.
- Latency: `count` takes a new value after edge N. The matching event is classified at edge N+1 and is visible until edge N+2.
- Pulses (`wrap_up`, `wrap_down`, `step_err`) are exactly one cycle wide per offending sample.
- Stall timing: `stall` asserts after STALL_LIM consecutive equal samples. It deasserts one edge after the first changed sample.
- Back-to-back wraps are possible only with CNT_W=1. Each one is counted individually.

## Test plan
- **Up wrap:** reset, then release the counter counting up; `count` sequence 0..15,0. At the 15→0 sample: `wrap_up`=1 for one cycle, `wrap_cnt`=1, `dir`=1, `step_err` never asserted.
- **Down wrap:** from `count`=2, drive 2,1,0,15,14. `wrap_down` pulses once, at the 0→15 sample. `wrap_cnt` increments by 1, `dir`=0 from the first down step.
- **Stall:** hold `count`=5 with STALL_LIM=8. `stall` rises after the 8th consecutive equal sample. When `count` moves to 6, `stall` falls the next cycle and `dir`=1.
- **Illegal step:** jump `count` 3→7. `step_err` pulses for one cycle, `err_sticky`=1 and stays high, `dir` is unchanged. Then assert `clear`: `err_sticky`=0 and `wrap_cnt`=0.
- **Saturation and priority:** with WRAP_W=2, generate 5 wraps; `wrap_cnt` holds at 3. Then assert `clear` on the same edge as a wrap: `wrap_cnt`=0 and `wrap_up` still pulses.
- **Reset mid-stream:** assert `reset` asynchronously between edges while `wrap_cnt`=2 and `stall`=1. All outputs drop to 0 immediately. After release, the first sample produces no event and `primed`=1.
